// File: rtl/dp_ir_ctl.sv
// JTAG instruction register for the debug port: capture/shift stage, update stage and a
// shift-length monitor, all clocked by iclk and advanced by single-cycle TCK edge strobes.
module dp_ir_ctl #(
   parameter int unsigned        IR_W   = 8,
   parameter logic [IR_W-1:0]    RST_IR = IR_W'('h55)
) (
   input  logic            iclk,
   input  logic            ireset,
   input  logic            tck_re,
   input  logic            tck_fe,
   input  logic            tlr,
   input  logic            capture_ir,
   input  logic            shift_ir,
   input  logic            update_ir,
   input  logic            sdi,
   output logic            sdo,
   output logic            sdo_en,
   input  logic [IR_W-1:0] pdi,
   output logic [IR_W-1:0] pdo,
   output logic            upd_stb,
   output logic            bypass,
   output logic            len_err
);

   localparam int unsigned       CNT_W    = $clog2(IR_W + 2);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(IR_W + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(IR_W);

   logic [IR_W-1:0]  sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sdo_q, sdo_d;
   logic             sdo_en_q, sdo_en_d;
   logic [IR_W-1:0]  pdo_q, pdo_d;
   logic             upd_stb_q, upd_stb_d;
   logic             len_err_q, len_err_d;
   logic [IR_W-1:0]  cap_val;

   // Low two bits of the captured value are the fixed 2'b01 JTAG pattern.
   always_comb begin
      cap_val      = pdi;
      cap_val[1:0] = 2'b01;
   end

   // TAP state levels are resolved tlr > capture > shift > update; falling-edge
   // actions read sr_q so a coincident rising edge cannot affect them.
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      sdo_d     = sdo_q;
      sdo_en_d  = sdo_en_q;
      pdo_d     = pdo_q;
      upd_stb_d = 1'b0;
      len_err_d = len_err_q;

      if (tlr) begin
         pdo_d     = RST_IR;
         len_err_d = 1'b0;
         sdo_en_d  = 1'b0;
      end else begin
         if (tck_re) begin
            if (capture_ir) begin
               sr_d  = cap_val;
               cnt_d = '0;
            end else if (shift_ir) begin
               sr_d = {sdi, sr_q[IR_W-1:1]};
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         if (tck_fe) begin
            if (capture_ir) begin
               sdo_en_d = 1'b0;
            end else if (shift_ir) begin
               sdo_d    = sr_q[0];
               sdo_en_d = 1'b1;
            end else begin
               sdo_en_d = 1'b0;
               if (update_ir) begin
                  pdo_d     = sr_q;
                  upd_stb_d = 1'b1;
                  len_err_d = (cnt_q != CNT_FULL);
               end
            end
         end
      end
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         sdo_q     <= 1'b0;
         sdo_en_q  <= 1'b0;
         pdo_q     <= RST_IR;
         upd_stb_q <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         sdo_q     <= sdo_d;
         sdo_en_q  <= sdo_en_d;
         pdo_q     <= pdo_d;
         upd_stb_q <= upd_stb_d;
         len_err_q <= len_err_d;
      end
   end

   assign sdo     = sdo_q;
   assign sdo_en  = sdo_en_q;
   assign pdo     = pdo_q;
   assign upd_stb = upd_stb_q;
   assign len_err = len_err_q;
   assign bypass  = &pdo_q;

endmodule

// File: tb/tb_dp_ir_ctl.sv
// Directed bench for dp_ir_ctl (IR_W=8, RST_IR=8'h55) with hand-computed expectations.
module tb_dp_ir_ctl;

   logic       iclk = 1'b0;
   logic       ireset = 1'b1;
   logic       tck_re = 1'b0, tck_fe = 1'b0;
   logic       tlr = 1'b0, capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
   logic       sdi = 1'b0;
   logic       sdo, sdo_en, upd_stb, bypass, len_err;
   logic [7:0] pdi = 8'h00;
   logic [7:0] pdo;

   int checks = 0;
   int failures = 0;

   dp_ir_ctl #(.IR_W(8), .RST_IR(8'h55)) dut (
      .iclk(iclk), .ireset(ireset), .tck_re(tck_re), .tck_fe(tck_fe), .tlr(tlr),
      .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir), .sdi(sdi),
      .sdo(sdo), .sdo_en(sdo_en), .pdi(pdi), .pdo(pdo), .upd_stb(upd_stb),
      .bypass(bypass), .len_err(len_err)
   );

   always #5 iclk = ~iclk;

   task automatic clk1();
      @(posedge iclk);
      #1;
   endtask

   task automatic capture(input logic [7:0] d);
      pdi = d; capture_ir = 1'b1; tck_re = 1'b1;
      clk1();
      tck_re = 1'b0; capture_ir = 1'b0;
   endtask

   // Shift n bits LSB first; outs[i] is sdo seen before bit i enters. Ends in Exit1.
   task automatic shift_bits(input logic [31:0] data, input int n,
                             output logic [31:0] outs, output logic en_all);
      outs = '0; en_all = 1'b1; shift_ir = 1'b1;
      for (int i = 0; i < n; i++) begin
         tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
         outs[i] = sdo; en_all = en_all & sdo_en;
         sdi = data[i]; tck_re = 1'b1; clk1(); tck_re = 1'b0;
      end
      shift_ir = 1'b0;
      tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
   endtask

   task automatic update(output logic stb_now, output logic stb_after);
      update_ir = 1'b1; tck_fe = 1'b1;
      clk1();
      stb_now = upd_stb;
      tck_fe = 1'b0; update_ir = 1'b0;
      clk1();
      stb_after = upd_stb;
   endtask

   task automatic test_reset();
      ireset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         {tck_re, tck_fe, tlr, capture_ir, shift_ir, update_ir, sdi} = 7'($urandom);
         pdi = 8'($urandom);
         clk1();
      end
      checks++; if (pdo !== 8'h55) begin failures++; $display("FAIL reset_pdo got=%h exp=55", pdo); end
      checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
      checks++; if (sdo_en !== 1'b0) begin failures++; $display("FAIL reset_sdo_en got=%b exp=0", sdo_en); end
      checks++; if (upd_stb !== 1'b0) begin failures++; $display("FAIL reset_upd_stb got=%b exp=0", upd_stb); end
      checks++; if (bypass !== 1'b0) begin failures++; $display("FAIL reset_bypass got=%b exp=0", bypass); end
      checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
      {tck_re, tck_fe, tlr, capture_ir, shift_ir, update_ir, sdi} = '0;
      pdi = 8'h00;
      ireset = 1'b0;
      clk1();
      checks++; if (pdo !== 8'h55) begin failures++; $display("FAIL reset_idle_pdo got=%h exp=55", pdo); end
   endtask

   task automatic test_full_scan();
      logic [31:0] outs; logic en_all, s0, s1;
      capture(8'hA4);
      shift_bits(32'h3C, 8, outs, en_all);
      checks++; if (outs[7:0] !== 8'hA5) begin failures++; $display("FAIL scan_sdo_seq got=%h exp=a5", outs[7:0]); end
      checks++; if (en_all !== 1'b1) begin failures++; $display("FAIL scan_sdo_en got=%b exp=1", en_all); end
      checks++; if (sdo_en !== 1'b0) begin failures++; $display("FAIL scan_sdo_en_exit got=%b exp=0", sdo_en); end
      update(s0, s1);
      checks++; if (pdo !== 8'h3C) begin failures++; $display("FAIL scan_pdo got=%h exp=3c", pdo); end
      checks++; if ({s0, s1} !== 2'b10) begin failures++; $display("FAIL scan_upd_stb got=%b exp=10", {s0, s1}); end
      checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL scan_len_err got=%b exp=0", len_err); end
      checks++; if (bypass !== 1'b0) begin failures++; $display("FAIL scan_bypass got=%b exp=0", bypass); end
   endtask

   task automatic test_bypass();
      logic [31:0] outs; logic en_all, s0, s1;
      capture(8'h00);
      shift_bits(32'hFF, 8, outs, en_all);
      checks++; if (outs[7:0] !== 8'h01) begin failures++; $display("FAIL byp_sdo_seq got=%h exp=01", outs[7:0]); end
      update(s0, s1);
      checks++; if (pdo !== 8'hFF) begin failures++; $display("FAIL byp_pdo got=%h exp=ff", pdo); end
      checks++; if (bypass !== 1'b1) begin failures++; $display("FAIL byp_bypass got=%b exp=1", bypass); end
   endtask

   task automatic test_len_err();
      logic [31:0] outs; logic en_all, s0, s1;
      capture(8'hA4);
      shift_bits(32'h1F, 5, outs, en_all);
      update(s0, s1);
      checks++; if (pdo !== 8'hFD) begin failures++; $display("FAIL len5_pdo got=%h exp=fd", pdo); end
      checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL len5_len_err got=%b exp=1", len_err); end
      capture(8'hA4);
      shift_bits(32'h358, 10, outs, en_all);
      update(s0, s1);
      checks++; if (pdo !== 8'hD6) begin failures++; $display("FAIL len10_pdo got=%h exp=d6", pdo); end
      checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL len10_len_err got=%b exp=1", len_err); end
      // 24 bits would wrap an unsaturated 4-bit counter back to 8
      capture(8'hA4);
      shift_bits(32'h5A0000, 24, outs, en_all);
      update(s0, s1);
      checks++; if (pdo !== 8'h5A) begin failures++; $display("FAIL len24_pdo got=%h exp=5a", pdo); end
      checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL len24_len_err got=%b exp=1", len_err); end
      capture(8'hA4);
      shift_bits(32'h81, 8, outs, en_all);
      update(s0, s1);
      checks++; if (pdo !== 8'h81) begin failures++; $display("FAIL len8_pdo got=%h exp=81", pdo); end
      checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL len8_len_err got=%b exp=0", len_err); end
   endtask

   task automatic test_tlr();
      logic [31:0] outs; logic en_all, s0, s1;
      capture(8'h00);
      shift_bits(32'h78, 9, outs, en_all);
      update(s0, s1);
      checks++; if ({pdo, len_err} !== {8'h3C, 1'b1}) begin
         failures++; $display("FAIL tlr_pre got=%h/%b exp=3c/1", pdo, len_err); end
      capture(8'h3C);
      shift_ir = 1'b1; sdi = 1'b0;
      tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
      tck_re = 1'b1; clk1(); tck_re = 1'b0;
      tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
      checks++; if (sdo_en !== 1'b1) begin failures++; $display("FAIL tlr_mid_sdo_en got=%b exp=1", sdo_en); end
      tlr = 1'b1; tck_re = 1'b1;
      clk1();
      tlr = 1'b0; tck_re = 1'b0;
      checks++; if (pdo !== 8'h55) begin failures++; $display("FAIL tlr_pdo got=%h exp=55", pdo); end
      checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL tlr_len_err got=%b exp=0", len_err); end
      checks++; if (sdo_en !== 1'b0) begin failures++; $display("FAIL tlr_sdo_en got=%b exp=0", sdo_en); end
      checks++; if (upd_stb !== 1'b0) begin failures++; $display("FAIL tlr_upd_stb got=%b exp=0", upd_stb); end
      // sr held at 8'h1E through tlr; a wrong shift would expose bit0=1
      tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
      checks++; if ({sdo, sdo_en} !== 2'b01) begin
         failures++; $display("FAIL tlr_sr_held got=%b exp=01", {sdo, sdo_en}); end
      shift_ir = 1'b0;
      tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
      tlr = 1'b1; update_ir = 1'b1; tck_fe = 1'b1;
      clk1();
      tlr = 1'b0; update_ir = 1'b0; tck_fe = 1'b0;
      checks++; if ({pdo, upd_stb} !== {8'h55, 1'b0}) begin
         failures++; $display("FAIL tlr_vs_update got=%h/%b exp=55/0", pdo, upd_stb); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] outs; logic en_all; logic [2:0] stb;
      capture(8'h00);
      shift_bits(32'h3C, 8, outs, en_all);
      update_ir = 1'b1; tck_fe = 1'b1;
      clk1(); stb[2] = upd_stb;
      clk1(); stb[1] = upd_stb;
      update_ir = 1'b0; tck_fe = 1'b0;
      clk1(); stb[0] = upd_stb;
      checks++; if (stb !== 3'b110) begin failures++; $display("FAIL b2b_upd_stb got=%b exp=110", stb); end
      checks++; if ({pdo, len_err} !== {8'h3C, 1'b0}) begin
         failures++; $display("FAIL b2b_pdo got=%h/%b exp=3c/0", pdo, len_err); end
   endtask

   task automatic test_collision();
      logic [31:0] outs; logic en_all;
      capture(8'h00);
      shift_bits(32'h12, 8, outs, en_all);
      ireset = 1'b1; update_ir = 1'b1; tck_fe = 1'b1;
      clk1();
      ireset = 1'b0; update_ir = 1'b0; tck_fe = 1'b0;
      checks++; if (pdo !== 8'h55) begin failures++; $display("FAIL col_rst_pdo got=%h exp=55", pdo); end
      checks++; if (upd_stb !== 1'b0) begin failures++; $display("FAIL col_rst_upd_stb got=%b exp=0", upd_stb); end
      clk1();
      checks++; if (upd_stb !== 1'b0) begin failures++; $display("FAIL col_rst_upd_late got=%b exp=0", upd_stb); end
      capture(8'hA4);
      shift_ir = 1'b1; sdi = 1'b0; tck_re = 1'b1; tck_fe = 1'b1;
      clk1();
      tck_re = 1'b0; tck_fe = 1'b0;
      checks++; if ({sdo, sdo_en} !== 2'b11) begin
         failures++; $display("FAIL col_edges_sdo got=%b exp=11", {sdo, sdo_en}); end
      tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
      checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL col_edges_next got=%b exp=0", sdo); end
      shift_ir = 1'b0;
      tck_fe = 1'b1; clk1(); tck_fe = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_bypass();
      test_len_err();
      test_tlr();
      test_back_to_back();
      test_collision();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
